pc_fetch_unit: RTL and testbench

//  Program-counter and next-PC stage of the single-cycle CPU. Drives the 7-bit word address into
//  the combinational instruction ROM. Each cycle, selects sequential, branch or jump successor.

---
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/pc_fetch_unit.sv | 92 +++++++++
 tb/tb_pc_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - fetch-stage control inputs and PC/status outputs
interface pc_fetch_unit_if;
    logic        stall;
    logic        br_taken;
    logic        jmp;
    logic [15:0] imm16;
    logic [25:0] jidx26;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [6:0]  addr;
    logic        pc_valid;
    logic        halted;
    logic        fault;
    logic [15:0] retired;

    modport master (
        output stall, br_taken, jmp, imm16, jidx26,
        input  pc, pc_plus4, addr, pc_valid, halted, fault, retired
    );

    modport slave (
        input  stall, br_taken, jmp, imm16, jidx26,
        output pc, pc_plus4, addr, pc_valid, halted, fault, retired
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter, next-PC select, run/halt FSM, retire counter
module pc_fetch_unit #(
    parameter int          PROG_WORDS = 77,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam logic [29:0] WORD_LIMIT = 30'(PROG_WORDS);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [15:0] retired_q, retired_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;

    assign pc_plus4 = pc_q + 32'd4;

    // Successor selection: jump beats branch beats fall-through.
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (bus.jmp) begin
            target   = {pc_plus4[31:28], bus.jidx26, 2'b00};
            redirect = 1'b1;
        end else if (bus.br_taken) begin
            target   = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
            redirect = 1'b1;
        end
    end

    // Next-state: BOOT bubble, RUN advance/retire, HALT on overrun or bad redirect.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        fault_d   = fault_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!bus.stall) begin
                    if (retired_q != 16'hFFFF) begin
                        retired_d = retired_q + 16'd1;
                    end
                    // Halting leaves pc on the last instruction so it stays observable.
                    if (target[31:2] >= WORD_LIMIT) begin
                        state_d = ST_HALT;
                        if (redirect) begin
                            fault_d = 1'b1;
                        end
                    end else begin
                        pc_d = target;
                    end
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= RESET_PC;
            retired_q <= 16'd0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.addr     = pc_q[8:2];
    assign bus.pc_valid = (state_q == ST_RUN);
    assign bus.halted   = (state_q == ST_HALT);
    assign bus.fault    = fault_q;
    assign bus.retired  = retired_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a reference model
module tb_pc_fetch_unit;
    localparam int N_WORDS = 77;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_fetch_unit_if bus();

    pc_fetch_unit #(.PROG_WORDS(N_WORDS), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: 0 = boot bubble, 1 = running, 2 = halted.
    int          m_mode;
    logic [31:0] m_pc;
    int          m_retired;
    bit          m_fault;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},       bus.pc,                 m_pc);
        check({tag, ".pc_plus4"}, bus.pc_plus4,           m_pc + 32'd4);
        check({tag, ".addr"},     32'(bus.addr),          32'(m_pc[8:2]));
        check({tag, ".pc_valid"}, 32'(bus.pc_valid),      32'(m_mode == 1));
        check({tag, ".halted"},   32'(bus.halted),        32'(m_mode == 2));
        check({tag, ".fault"},    32'(bus.fault),         32'(m_fault));
        check({tag, ".retired"},  32'(bus.retired),       32'(m_retired));
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_pc      = 32'h0;
        m_retired = 0;
        m_fault   = 1'b0;
    endtask

    task automatic model_clock(input bit s, input bit b, input bit j,
                               input logic [15:0] imm, input logic [25:0] jx);
        logic [31:0] nxt;
        logic [31:0] p4;
        bit          red;
        int          off;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1 && !s) begin
            if (m_retired < 65535) m_retired++;
            p4  = m_pc + 32'd4;
            red = j || b;
            if (j) begin
                nxt = {p4[31:28], jx, 2'b00};
            end else if (b) begin
                off = int'($signed(imm));
                nxt = p4 + 32'(off * 4);
            end else begin
                nxt = p4;
            end
            if (nxt / 4 >= N_WORDS) begin
                m_mode = 2;
                if (red) m_fault = 1'b1;
            end else begin
                m_pc = nxt;
            end
        end
    endtask

    task automatic step(input string tag, input bit s, input bit b, input bit j,
                        input logic [15:0] imm, input logic [25:0] jx);
        bus.stall    = s;
        bus.br_taken = b;
        bus.jmp      = j;
        bus.imm16    = imm;
        bus.jidx26   = jx;
        @(posedge clk);
        model_clock(s, b, j, imm, jx);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
    endtask

    task automatic apply_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("boot");
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.stall    = 1'b0;
        bus.br_taken = 1'b0;
        bus.jmp      = 1'b0;
        bus.imm16    = 16'h0;
        bus.jidx26   = 26'h0;
        model_reset();

        // Sequential start-up with BOOT bubble.
        @(negedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        #1;
        check_all("boot");
        for (int i = 0; i < 3; i++) idle("seq_start");
        check("retired_after_start", 32'(bus.retired), 32'd2);

        // Branches around word 8.
        step("jmp_to_8", 1'b0, 1'b0, 1'b1, 16'h0, 26'h8);
        check("at_word8", 32'(bus.addr), 32'h08);
        step("br_fwd", 1'b0, 1'b1, 1'b0, 16'h0001, 26'h0);
        check("br_fwd_addr", 32'(bus.addr), 32'h0A);
        step("jmp_to_8b", 1'b0, 1'b0, 1'b1, 16'h0, 26'h8);
        step("br_back", 1'b0, 1'b1, 1'b0, 16'hFFFE, 26'h0);
        check("br_back_addr", 32'(bus.addr), 32'h07);

        // Jump priority at word 0x2B.
        step("jmp_to_2b", 1'b0, 1'b0, 1'b1, 16'h0, 26'h2B);
        step("jmp_d", 1'b0, 1'b0, 1'b1, 16'h0, 26'h0D);
        check("jmp_pc", bus.pc, 32'h34);
        step("jmp_over_br", 1'b0, 1'b1, 1'b1, 16'h0010, 26'h20);
        check("jmp_wins_addr", 32'(bus.addr), 32'h20);

        // Stall holds pc and retire count, drops redirects.
        step("jmp_to_5", 1'b0, 1'b0, 1'b1, 16'h0, 26'h5);
        step("stall0", 1'b1, 1'b0, 1'b0, 16'h0, 26'h0);
        step("stall1", 1'b1, 1'b0, 1'b1, 16'h0, 26'h30);
        step("stall2", 1'b1, 1'b1, 1'b0, 16'h0004, 26'h0);
        check("stall_addr", 32'(bus.addr), 32'h05);

        // Sequential overrun halts cleanly at word 0x4C.
        step("jmp_to_48", 1'b0, 1'b0, 1'b1, 16'h0, 26'h48);
        for (int i = 0; i < 4; i++) idle("seq_to_4c");
        check("at_word4c", bus.pc, 32'h130);
        idle("seq_halt");
        check("seq_halt_halted", 32'(bus.halted), 32'd1);
        check("seq_halt_fault", 32'(bus.fault), 32'd0);
        check("seq_halt_pc", bus.pc, 32'h130);
        step("halt_ign_j", 1'b0, 1'b0, 1'b1, 16'h0, 26'h3);
        step("halt_ign_b", 1'b0, 1'b1, 1'b0, 16'hFFF0, 26'h0);

        // Redirect fault, then mid-run reset.
        apply_reset();
        idle("boot_exit");
        idle("run1");
        step("jmp_fault", 1'b0, 1'b0, 1'b1, 16'h0, 26'h7F);
        check("fault_set", 32'(bus.fault), 32'd1);
        check("fault_pc", bus.pc, 32'h4);
        idle("fault_hold");
        apply_reset();
        idle("boot_exit2");
        for (int i = 0; i < 3; i++) idle("run_pre_rst");
        apply_reset();
        check("mid_rst_retired", 32'(bus.retired), 32'd0);

        // Randomized runs against the model.
        for (int r = 0; r < 25; r++) begin
            apply_reset();
            for (int c = 0; c < 300 && m_mode != 2; c++) begin
                bit          s;
                bit          b;
                bit          j;
                logic [15:0] imm;
                logic [25:0] jx;
                s   = ($urandom_range(0, 3) == 0);
                b   = ($urandom_range(0, 4) == 0);
                j   = ($urandom_range(0, 9) == 0);
                imm = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                  : 16'($signed(int'($urandom_range(0, 20)) - 10));
                jx  = ($urandom_range(0, 7) == 0) ? 26'($urandom)
                                                  : 26'($urandom_range(0, N_WORDS - 1));
                step("rand", s, b, j, imm, jx);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
